vr16_control_unit: RTL and testbench
====================================

// Module: vr16_control_unit
// PURPOSE
// - Multi-cycle sequencer for the VR16 core: fetches 16-bit instructions, decodes them, and drives the ALU issue interface.
// - Owns the PC and a register file. Executes LOAD/JUMP/STORE/HALT itself and writes ALU results back.
// - Instruction word: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2 or imm. Memory ops use [7:0] as the address.
// PARAMETERS
// - NUM_REGS  16  register file depth; register fields are 4 bits, so this must be 16.
// - DATA_W    16  register and data-memory word width.
// - PC_W       8  PC and memory address width.
// PORTS
// - clk          in   1       clock, rising edge.
// - reset        in   1       asynchronous, active-high.
// - run          in   1       allows leaving IDLE.
// - imem_req     out  1       instruction read request.
// - imem_addr    out  PC_W    equals PC.
// - imem_valid   in   1       imem_data valid. Sampled only while imem_req=1.
// - imem_data    in   16      instruction word.
// - dmem_req     out  1       data access request.
// - dmem_we      out  1       1=STORE, 0=LOAD.
// - dmem_addr    out  PC_W    data address.
// - dmem_wdata   out  DATA_W  store data.
// - dmem_valid   in   1       access complete. For LOAD, rdata is valid in the same cycle.
// - dmem_rdata   in   DATA_W  load data.
// - alu_enable   out  1       one-cycle ALU issue strobe.
// - alu_opcode   out  4       ALU opcode.
// - alu_imm      out  4       ir[3:0].
// - alu_op_one   out  4       R[rs1][3:0].
// - alu_op_two   out  4       R[rs2][3:0].
// - alu_result   in   16      ALU output, registered on the alu_enable edge.
// - pc_out       out  PC_W    current PC.
// - halted       out  1       in HALT state.
// - fault        out  1       divide-by-zero trap (DIV0_TRAP_EN only; otherwise tied to 0).
// BEHAVIOUR
// - Reset (async): state=IDLE, PC=0, IR=0, all registers=0. Every output is 0.
//   - Request and strobe outputs are decoded from the state register, so they drop as reset asserts.
// - IDLE -> FETCH when run=1.
// - FETCH: imem_req=1 and imem_addr=PC, held until imem_valid.
//   - On imem_valid: IR<=imem_data, PC<=PC+1 (wraps 0xFF->0x00), go to DECODE.
// - DECODE (1 cycle):
//   - op 0000-0111 or 1011-1110 -> EXEC.
//   - 1000 LOAD / 1010 STORE -> MEM.
//   - 1001 JUMP: PC<=IR[7:0], go to FETCH.
//   - 1111 HALT -> HALT.
// - EXEC (1 cycle): alu_enable=1 with opcode, imm and operands valid -> WB.
// - WB (1 cycle): R[rd]<=alu_result, go to FETCH if run=1, else IDLE.
//   - Fetch-to-fetch latency for an ALU op: FETCH + 3 cycles.
// - MEM: dmem_req=1 and dmem_addr=IR[7:0], held until dmem_valid.
//   - STORE: dmem_we=1, dmem_wdata=R[IR[11:8]].
//   - LOAD: on dmem_valid, R[rd]<=dmem_rdata. Then go to FETCH (or IDLE if run=0).
// - HALT: halted=1, absorbing. Only reset exits.
// - Width rules:
//   - Operands are truncated to 4 bits.
//   - The full 16-bit alu_result is written to R[rd].
//   - rd may equal rs1/rs2; the read occurs in EXEC, the write in WB.
// - Boundaries:
//   - imem_valid/dmem_valid outside FETCH/MEM are ignored.
//   - run dropping mid-instruction completes the current instruction first.
//   - JUMP to the current PC loops forever.
//   - Reset in any state aborts with no register or memory write.
// CONFIGURATION
// - VR16_DIV0_TRAP_EN defined: in DECODE, DIV with R[rs2][3:0]==0, or DIVI with imm==0, skips EXEC.
//   - Sets fault=1 and goes to HALT. No writeback occurs.
// - VR16_DIV0_TRAP_EN undefined: the instruction issues normally and R[rd] takes whatever the ALU returns. fault=0 always.
// TESTING
// - Reset, run=1, imem 0x0: 0x1103 (ADDI r1,r0,3) -> alu_enable pulse with op=0001, imm=3; r1=0x0003; pc_out=1.
// - Program ADDI r1,r0,5; ADDI r2,r0,6; ADD r3,r1,r2 (0x0312) -> r3=0x000B; exactly 3 alu_enable pulses.
// - STORE r3 to 0x40 (0xA340), then LOAD r4 from 0x40 (0x8440), dmem_valid delayed 3 cycles:
//   - dmem_req held 3 cycles; dmem_wdata=0x000B; r4=0x000B.
// - JUMP 0x10 (0x9010) at PC 0x05 -> next imem_addr=0x10. HALT (0xF000) -> halted=1; imem_req stays 0 for 20 cycles.
// - DIVI r1,r1,0 (0x7110): with VR16_DIV0_TRAP_EN -> fault=1, halted=1, no alu_enable; without -> alu_enable pulses, fault=0.
// - Assert reset during MEM of a STORE -> dmem_req drops in the same cycle; PC=0; state IDLE; registers cleared.

Source files
------------

// File: rtl/vr16_control_unit.sv
// vr16_control_unit: multi-cycle fetch/decode/execute sequencer for the VR16 core.
// Owns the PC, instruction register and register file, executes LOAD/STORE/JUMP/HALT
// itself and issues everything else to the external ALU, writing the result back.
// Optional build macro: VR16_DIV0_TRAP_EN -- DIV/DIVI by zero is trapped in DECODE
// (fault=1, HALT, no ALU issue, no writeback). Without it fault is tied low.
module vr16_control_unit #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int PC_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [PC_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_valid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              alu_enable,
  output logic [3:0]        alu_opcode,
  output logic [3:0]        alu_imm,
  output logic [3:0]        alu_op_one,
  output logic [3:0]        alu_op_two,
  input  logic [15:0]       alu_result,
  output logic [PC_W-1:0]   pc_out,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_MEM    = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_DIV   = 4'h6;
  localparam logic [3:0] OP_DIVI  = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t              state_r;
  logic [PC_W-1:0]     pc_r;
  logic [15:0]         ir_r;
  logic [DATA_W-1:0]   regs_r [NUM_REGS];

  logic [3:0]          opcode_s;
  logic [3:0]          rd_s;
  logic [3:0]          rs1_s;
  logic [3:0]          rs2_s;
  logic [DATA_W-1:0]   rs1_val_s;
  logic [DATA_W-1:0]   rs2_val_s;
  logic [DATA_W-1:0]   rd_val_s;
  logic                is_store_s;

  // Instruction field extraction and register reads (all from registered state)
  assign opcode_s   = ir_r[15:12];
  assign rd_s       = ir_r[11:8];
  assign rs1_s      = ir_r[7:4];
  assign rs2_s      = ir_r[3:0];
  assign rs1_val_s  = regs_r[rs1_s];
  assign rs2_val_s  = regs_r[rs2_s];
  assign rd_val_s   = regs_r[rd_s];
  assign is_store_s = (opcode_s == OP_STORE);

`ifdef VR16_DIV0_TRAP_EN
  logic fault_r;
  logic div0_s;

  // Detect a zero divisor on the instruction currently held in IR
  always_comb begin
    div0_s = 1'b0;
    if (opcode_s == OP_DIV) begin
      div0_s = (rs2_val_s[3:0] == 4'h0);
    end else if (opcode_s == OP_DIVI) begin
      div0_s = (ir_r[3:0] == 4'h0);
    end else begin
      div0_s = 1'b0;
    end
  end

  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

  // Sequencer: state, PC, IR and register file updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pc_r    <= '0;
      ir_r    <= 16'h0000;
`ifdef VR16_DIV0_TRAP_EN
      fault_r <= 1'b0;
`endif
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run) begin
            state_r <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (imem_valid) begin
            ir_r    <= imem_data;
            pc_r    <= pc_r + PC_W'(1);
            state_r <= ST_DECODE;
          end
        end
        ST_DECODE: begin
`ifdef VR16_DIV0_TRAP_EN
          if (div0_s) begin
            fault_r <= 1'b1;
            state_r <= ST_HALT;
          end else begin
`endif
            case (opcode_s)
              OP_LOAD, OP_STORE: state_r <= ST_MEM;
              OP_JUMP: begin
                pc_r    <= PC_W'(ir_r[7:0]);
                state_r <= ST_FETCH;
              end
              OP_HALT: state_r <= ST_HALT;
              default: state_r <= ST_EXEC;
            endcase
`ifdef VR16_DIV0_TRAP_EN
          end
`endif
        end
        ST_EXEC: begin
          state_r <= ST_WB;
        end
        ST_WB: begin
          regs_r[rd_s] <= DATA_W'(alu_result);
          state_r      <= run ? ST_FETCH : ST_IDLE;
        end
        ST_MEM: begin
          if (dmem_valid) begin
            if (!is_store_s) begin
              regs_r[rd_s] <= dmem_rdata;
            end
            state_r <= run ? ST_FETCH : ST_IDLE;
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Interface outputs decoded from registered state so they drop with reset
  assign imem_req   = (state_r == ST_FETCH);
  assign imem_addr  = pc_r;
  assign dmem_req   = (state_r == ST_MEM);
  assign dmem_we    = (state_r == ST_MEM) && is_store_s;
  assign dmem_addr  = PC_W'(ir_r[7:0]);
  assign dmem_wdata = rd_val_s;
  assign alu_enable = (state_r == ST_EXEC);
  assign alu_opcode = opcode_s;
  assign alu_imm    = ir_r[3:0];
  assign alu_op_one = rs1_val_s[3:0];
  assign alu_op_two = rs2_val_s[3:0];
  assign pc_out     = pc_r;
  assign halted     = (state_r == ST_HALT);

endmodule

// File: tb/tb_vr16_control_unit.sv
// tb_vr16_control_unit: directed self-checking bench for vr16_control_unit.
// Provides instruction memory, a latency-programmable data memory and a small ALU.
module tb_vr16_control_unit;

  logic        clk;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_valid;
  logic [15:0] dmem_rdata;
  logic        alu_enable;
  logic [3:0]  alu_opcode;
  logic [3:0]  alu_imm;
  logic [3:0]  alu_op_one;
  logic [3:0]  alu_op_two;
  logic [15:0] alu_result;
  logic [7:0]  pc_out;
  logic        halted;
  logic        fault;

  vr16_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_valid (dmem_valid),
    .dmem_rdata (dmem_rdata),
    .alu_enable (alu_enable),
    .alu_opcode (alu_opcode),
    .alu_imm    (alu_imm),
    .alu_op_one (alu_op_one),
    .alu_op_two (alu_op_two),
    .alu_result (alu_result),
    .pc_out     (pc_out),
    .halted     (halted),
    .fault      (fault)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic        imem_force;
  int          dmem_lat;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;

  int          cyc = 0;
  int          alu_cnt = 0;
  int          req_cyc = 0;
  int          ifetch_cnt = 0;
  int          st_cnt = 0;
  int          dcnt = 0;
  logic [3:0]  last_op, last_imm, last_a, last_b;
  logic [15:0] last_wdata;

  // Reference ALU: DIV/DIVI by zero return all ones
  function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic [3:0] imm);
    case (op)
      4'h0:    alu_model = 16'(a) + 16'(b);
      4'h1:    alu_model = 16'(a) + 16'(imm);
      4'h6:    alu_model = (b == 4'h0) ? 16'hFFFF : 16'(a / b);
      4'h7:    alu_model = (imm == 4'h0) ? 16'hFFFF : 16'(a / imm);
      default: alu_model = 16'(a ^ b);
    endcase
  endfunction

  assign imem_valid = imem_req | imem_force;
  assign imem_data  = imem[imem_addr];
  assign dmem_valid = dmem_req && (dcnt == dmem_lat - 1);
  assign dmem_rdata = dmem[dmem_addr];

  // Environment monitors, ALU result register and data-memory handshake counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_enable) begin
      alu_cnt    <= alu_cnt + 1;
      last_op    <= alu_opcode;
      last_imm   <= alu_imm;
      last_a     <= alu_op_one;
      last_b     <= alu_op_two;
      alu_result <= alu_model(alu_opcode, alu_op_one, alu_op_two, alu_imm);
    end
    if (dmem_req) req_cyc <= req_cyc + 1;
    if (imem_req) ifetch_cnt <= ifetch_cnt + 1;
    if (dmem_req && dmem_valid && dmem_we) begin
      st_cnt     <= st_cnt + 1;
      last_wdata <= dmem_wdata;
    end
    if (dmem_req && !dmem_valid) dcnt <= dcnt + 1;
    else dcnt <= 0;
  end

  // Data memory storage: bench preload port or DUT store
  always @(posedge clk) begin
    if (ld_en) dmem[ld_addr] <= ld_data;
    else if (dmem_req && dmem_valid && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_dmem(input logic [7:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic wait_fetch(input string tag, input logic [7:0] a, input int budget);
    int n;
    n = 0;
    while (!(imem_req && imem_addr == a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, (imem_req && imem_addr == a)}, 32'd1);
  endtask

  task automatic wait_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed test sequence
  initial begin
    int t0, a0, r0, s0, f0, n, bad;
    reset = 1'b1; run = 1'b0; imem_force = 1'b0; dmem_lat = 3;
    ld_en = 1'b0; ld_addr = 8'h00; ld_data = 16'h0000;
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
    clear_imem();
    imem[8'h00] = 16'h1103; // ADDI r1,r0,3
    imem[8'h01] = 16'h1105; // ADDI r1,r0,5
    imem[8'h02] = 16'h1206; // ADDI r2,r0,6
    imem[8'h03] = 16'h0312; // ADD  r3,r1,r2
    imem[8'h04] = 16'hA340; // STORE r3 -> 0x40
    imem[8'h05] = 16'h9010; // JUMP 0x10
    imem[8'h10] = 16'h8440; // LOAD r4 <- 0x40
    imem[8'h11] = 16'h8541; // LOAD r5 <- 0x41
    imem[8'h12] = 16'h0655; // ADD  r6,r5,r5 (operands truncated)
    imem[8'h13] = 16'h7110; // DIVI r1,r1,0
    imem[8'h14] = 16'hF000; // HALT
    @(negedge clk);
    load_dmem(8'h41, 16'h1234);

    // Reset state
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_alu_en", {31'd0, alu_enable}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_pc", {24'd0, pc_out}, 32'd0);

    // Program A: ALU ops, store/load, jump, divide by zero, halt
    imem_force = 1'b1;
    reset = 1'b0; run = 1'b1;
    wait_fetch("fetch_00", 8'h00, 10);
    t0 = cyc; a0 = alu_cnt;
    wait_fetch("fetch_01", 8'h01, 10);
    chk("alu_latency", cyc - t0, 32'd4);
    chk("addi_r1", {16'd0, dut.regs_r[1]}, 32'h0003);
    chk("addi_pc", {24'd0, pc_out}, 32'h01);
    chk("addi_pulses", alu_cnt - a0, 32'd1);
    chk("addi_op", {28'd0, last_op}, 32'h1);
    chk("addi_imm", {28'd0, last_imm}, 32'h3);
    a0 = alu_cnt;
    wait_fetch("fetch_04", 8'h04, 20);
    chk("add_r3", {16'd0, dut.regs_r[3]}, 32'h000B);
    chk("add_pulses", alu_cnt - a0, 32'd3);
    chk("add_op_one", {28'd0, last_a}, 32'h5);
    chk("add_op_two", {28'd0, last_b}, 32'h6);
    r0 = req_cyc; s0 = st_cnt;
    wait_fetch("fetch_05", 8'h05, 20);
    chk("store_req_cycles", req_cyc - r0, 32'd3);
    chk("store_count", st_cnt - s0, 32'd1);
    chk("store_wdata", {16'd0, last_wdata}, 32'h000B);
    chk("store_mem", {16'd0, dmem[8'h40]}, 32'h000B);
    t0 = cyc;
    wait_fetch("jump_target", 8'h10, 10);
    chk("jump_latency", cyc - t0, 32'd2);
    r0 = req_cyc;
    wait_fetch("fetch_11", 8'h11, 20);
    chk("load_r4", {16'd0, dut.regs_r[4]}, 32'h000B);
    chk("load_req_cycles", req_cyc - r0, 32'd3);
    wait_fetch("fetch_13", 8'h13, 30);
    chk("load_r5", {16'd0, dut.regs_r[5]}, 32'h1234);
    chk("trunc_r6", {16'd0, dut.regs_r[6]}, 32'h0008);
    a0 = alu_cnt;
`ifdef VR16_DIV0_TRAP_EN
    n = 0;
    while (!halted && n < 10) begin @(negedge clk); n++; end
    chk("div0_halted", {31'd0, halted}, 32'd1);
    chk("div0_fault", {31'd0, fault}, 32'd1);
    chk("div0_no_issue", alu_cnt - a0, 32'd0);
    chk("div0_r1_kept", {16'd0, dut.regs_r[1]}, 32'h0005);
    chk("div0_pc", {24'd0, pc_out}, 32'h14);
`else
    wait_fetch("fetch_14", 8'h14, 10);
    chk("divi_issue", alu_cnt - a0, 32'd1);
    chk("divi_r1", {16'd0, dut.regs_r[1]}, 32'hFFFF);
    chk("divi_fault", {31'd0, fault}, 32'd0);
    n = 0;
    while (!halted && n < 10) begin @(negedge clk); n++; end
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_pc", {24'd0, pc_out}, 32'h15);
`endif
    f0 = ifetch_cnt;
    wait_cycles(20);
    chk("halt_no_fetch", ifetch_cnt - f0, 32'd0);
    chk("halt_stays", {31'd0, halted}, 32'd1);

    // Program B: idle with run low, run dropping mid-instruction, jump-to-self loop
    imem_force = 1'b0; run = 1'b0; reset = 1'b1;
    clear_imem();
    imem[8'h00] = 16'h1207; // ADDI r2,r0,7
    imem[8'h01] = 16'h9001; // JUMP 0x01 (self loop)
    wait_cycles(2);
    reset = 1'b0;
    f0 = ifetch_cnt;
    wait_cycles(5);
    chk("idle_no_fetch", ifetch_cnt - f0, 32'd0);
    run = 1'b1;
    n = 0;
    while (!alu_enable && n < 10) begin @(negedge clk); n++; end
    chk("runB_issue", {31'd0, alu_enable}, 32'd1);
    run = 1'b0;
    wait_cycles(3);
    chk("rundrop_r2", {16'd0, dut.regs_r[2]}, 32'h0007);
    chk("rundrop_idle", {31'd0, imem_req}, 32'd0);
    chk("rundrop_pc", {24'd0, pc_out}, 32'h01);
    run = 1'b1;
    wait_fetch("loop_fetch", 8'h01, 10);
    f0 = ifetch_cnt; a0 = alu_cnt; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr != 8'h01) bad++;
    end
    chk("loop_addr", bad, 32'd0);
    chk("loop_fetches", ifetch_cnt - f0, 32'd10);
    chk("loop_no_alu", alu_cnt - a0, 32'd0);

    // Program C: reset asserted while a STORE waits in MEM
    run = 1'b0; reset = 1'b1; dmem_lat = 10;
    clear_imem();
    imem[8'h00] = 16'h1107; // ADDI r1,r0,7
    imem[8'h01] = 16'hA140; // STORE r1 -> 0x40
    load_dmem(8'h40, 16'h5555);
    reset = 1'b0; run = 1'b1;
    n = 0;
    while (!dmem_req && n < 20) begin @(negedge clk); n++; end
    chk("storeC_req", {31'd0, dmem_req}, 32'd1);
    wait_cycles(2);
    chk("storeC_we", {31'd0, dmem_we}, 32'd1);
    chk("storeC_wdata", {16'd0, dmem_wdata}, 32'h0007);
    chk("storeC_addr", {24'd0, dmem_addr}, 32'h40);
    s0 = st_cnt;
    reset = 1'b1;
    #1;
    chk("abort_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("abort_pc", {24'd0, pc_out}, 32'd0);
    chk("abort_r1", {16'd0, dut.regs_r[1]}, 32'd0);
    chk("abort_imem_req", {31'd0, imem_req}, 32'd0);
    wait_cycles(3);
    chk("abort_no_store", st_cnt - s0, 32'd0);
    chk("abort_mem_kept", {16'd0, dmem[8'h40]}, 32'h5555);
    run = 1'b0;
    reset = 1'b0;
    wait_cycles(3);
    chk("abort_idle", {31'd0, imem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
